// File: rtl/cpu_bus_responder.sv
// CPU bus target: work RAM, peripheral port with req/ack handshake and timeout,
// and an open-bus latch for reads from unmapped space.
module cpu_bus_responder #(
  parameter int RAM_AW  = 11,
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        bus_valid_i,
  input  logic [15:0] addr_i,
  input  logic        r_w_n_i,
  input  logic [7:0]  d_in_i,
  output logic [7:0]  d_out_o,
  output logic        d_oe_o,
  output logic        resp_valid_o,
  output logic        rdy_o,
  output logic        per_req_o,
  output logic        per_we_o,
  output logic [2:0]  per_addr_o,
  output logic [7:0]  per_wdata_o,
  input  logic [7:0]  per_rdata_i,
  input  logic        per_ack_i,
  output logic        err_o
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, RAM_RD, PER_WAIT} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0]        dOut_q, dOut_d;
  logic              dOe_q, dOe_d;
  logic              resp_q, resp_d;
  logic              rdy_q, rdy_d;
  logic              perReq_q, perReq_d;
  logic              perWe_q, perWe_d;
  logic [2:0]        perAddr_q, perAddr_d;
  logic [7:0]        perWdata_q, perWdata_d;
  logic              err_q, err_d;
  logic [7:0]        openBus_q, openBus_d;
  logic [7:0]        ramRdata_q;
  logic              ramWe;
  logic              isRam, isPer;
  logic [RAM_AW-1:0] ramIdx;
  logic              unusedAddr;

  logic [7:0] mem [0:(1<<RAM_AW)-1];

  assign isRam      = (addr_i[15:13] == 3'b000);
  assign isPer      = (addr_i[15:13] == 3'b001);
  assign ramIdx     = addr_i[RAM_AW-1:0];
  assign unusedAddr = ^addr_i;

  // RAM is never reset; the read port samples every cycle so RAM_RD sees the accepted address
  always_ff @(posedge clk_i) begin
    if (ramWe && !reset_i) mem[ramIdx] <= d_in_i;
    ramRdata_q <= mem[ramIdx];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dOut_d     = dOut_q;
    dOe_d      = 1'b0;
    resp_d     = 1'b0;
    rdy_d      = rdy_q;
    perReq_d   = perReq_q;
    perWe_d    = perWe_q;
    perAddr_d  = perAddr_q;
    perWdata_d = perWdata_q;
    err_d      = 1'b0;
    openBus_d  = openBus_q;
    ramWe      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus_valid_i) begin
          if (isRam) begin
            if (!r_w_n_i) begin
              ramWe     = 1'b1;
              resp_d    = 1'b1;
              openBus_d = d_in_i;
            end else begin
              state_d = RAM_RD;
              dOe_d   = 1'b1;
              resp_d  = 1'b1;
            end
          end else if (isPer) begin
            state_d    = PER_WAIT;
            cnt_d      = '0;
            perReq_d   = 1'b1;
            perWe_d    = !r_w_n_i;
            perAddr_d  = addr_i[2:0];
            perWdata_d = d_in_i;
            rdy_d      = 1'b0;
            if (!r_w_n_i) openBus_d = d_in_i;
          end else begin
            resp_d = 1'b1;
            if (r_w_n_i) begin
              dOut_d = openBus_q;
              dOe_d  = 1'b1;
            end else begin
              openBus_d = d_in_i;
            end
          end
        end
      end
      RAM_RD: begin
        state_d   = IDLE;
        dOut_d    = ramRdata_q;
        openBus_d = ramRdata_q;
      end
      PER_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // An ack arriving on the last allowed cycle still completes normally
        if (per_ack_i) begin
          state_d  = IDLE;
          perReq_d = 1'b0;
          rdy_d    = 1'b1;
          resp_d   = 1'b1;
          if (!perWe_q) begin
            dOut_d    = per_rdata_i;
            dOe_d     = 1'b1;
            openBus_d = per_rdata_i;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d  = IDLE;
          perReq_d = 1'b0;
          rdy_d    = 1'b1;
          resp_d   = 1'b1;
          err_d    = 1'b1;
          if (!perWe_q) begin
            dOut_d = openBus_q;
            dOe_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dOut_q     <= 8'h00;
      dOe_q      <= 1'b0;
      resp_q     <= 1'b0;
      rdy_q      <= 1'b1;
      perReq_q   <= 1'b0;
      perWe_q    <= 1'b0;
      perAddr_q  <= 3'd0;
      perWdata_q <= 8'h00;
      err_q      <= 1'b0;
      openBus_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dOut_q     <= dOut_d;
      dOe_q      <= dOe_d;
      resp_q     <= resp_d;
      rdy_q      <= rdy_d;
      perReq_q   <= perReq_d;
      perWe_q    <= perWe_d;
      perAddr_q  <= perAddr_d;
      perWdata_q <= perWdata_d;
      err_q      <= err_d;
      openBus_q  <= openBus_d;
    end
  end

  // RAM read data is presented straight from the RAM register during RAM_RD
  assign d_out_o      = (state_q == RAM_RD) ? ramRdata_q : dOut_q;
  assign d_oe_o       = dOe_q;
  assign resp_valid_o = resp_q;
  assign rdy_o        = rdy_q;
  assign per_req_o    = perReq_q;
  assign per_we_o     = perWe_q;
  assign per_addr_o   = perAddr_q;
  assign per_wdata_o  = perWdata_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Scoreboard bench for cpu_bus_responder: stimulus pushes expected responses from a
// behavioural model, a negedge monitor pops and compares whenever resp_valid is seen.
module tb_cpu_bus_responder;

  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic       oe;
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_valid;
  logic [15:0] addr;
  logic        r_w_n;
  logic [7:0]  d_in;
  logic [7:0]  d_out;
  logic        d_oe;
  logic        resp_valid;
  logic        rdy;
  logic        per_req;
  logic        per_we;
  logic [2:0]  per_addr;
  logic [7:0]  per_wdata;
  logic [7:0]  per_rdata;
  logic        per_ack;
  logic        err;

  int   total = 0;
  int   bad   = 0;
  exp_t expQ[$];

  logic [7:0] memModel [0:2047];
  logic [7:0] openBus;

  always #5 clk = ~clk;

  cpu_bus_responder #(.RAM_AW(11), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .reset_i(reset), .bus_valid_i(bus_valid), .addr_i(addr),
    .r_w_n_i(r_w_n), .d_in_i(d_in), .d_out_o(d_out), .d_oe_o(d_oe),
    .resp_valid_o(resp_valid), .rdy_o(rdy), .per_req_o(per_req), .per_we_o(per_we),
    .per_addr_o(per_addr), .per_wdata_o(per_wdata), .per_rdata_i(per_rdata),
    .per_ack_i(per_ack), .err_o(err)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  // Every resp_valid consumes one expectation; outside responses d_oe and err must stay low
  always @(negedge clk) begin
    if (!reset) begin
      if (resp_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("resp_oe", {31'd0, d_oe}, {31'd0, e.oe});
          checkOutput("resp_err", {31'd0, err}, {31'd0, e.err});
          if (e.oe) checkOutput("resp_data", {24'd0, d_out}, {24'd0, e.data});
        end
      end else begin
        checkOutput("idle_oe", {31'd0, d_oe}, 32'd0);
        checkOutput("idle_err", {31'd0, err}, 32'd0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic rw, input logic [7:0] d);
    bus_valid = 1'b1;
    addr      = a;
    r_w_n     = rw;
    d_in      = d;
    @(posedge clk);
    #1;
    bus_valid = 1'b0;
  endtask

  // RAM or unmapped access; the response is due in the very next cycle
  task automatic applyStimulus(input logic [15:0] a, input logic rw, input logic [7:0] d);
    exp_t e;
    e.err  = 1'b0;
    e.oe   = rw;
    e.data = 8'h00;
    if (a < 16'h2000) begin
      if (rw) begin
        e.data  = memModel[a % 2048];
        openBus = e.data;
      end else begin
        memModel[a % 2048] = d;
        openBus = d;
      end
    end else begin
      if (rw) e.data = openBus;
      else    openBus = d;
    end
    expQ.push_back(e);
    drive(a, rw, d);
    checkOutput("resp_latency", {31'd0, resp_valid}, 32'd1);
    if (rw && a < 16'h2000) idle(1);
  endtask

  // Peripheral access acked after ackAt request cycles (ackAt >= TIMEOUT means never)
  task automatic perAccess(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                           input int ackAt, input logic [7:0] rd, input logic intrude);
    exp_t e;
    logic timedOut;
    int   low;
    int   done;
    timedOut = (ackAt >= TIMEOUT);
    e.err    = timedOut;
    e.oe     = rw;
    e.data   = rw ? (timedOut ? openBus : rd) : 8'h00;
    openBus  = rw ? e.data : wd;
    expQ.push_back(e);
    drive(a, rw, wd);
    low  = 0;
    done = 0;
    for (int i = 0; i < TIMEOUT + 8; i++) begin
      if (!per_req) begin
        done = 1;
        break;
      end
      if (i == 0) begin
        checkOutput("per_addr", {29'd0, per_addr}, {29'd0, a[2:0]});
        checkOutput("per_we", {31'd0, per_we}, {31'd0, !rw});
        if (!rw) checkOutput("per_wdata", {24'd0, per_wdata}, {24'd0, wd});
      end
      if (!rdy) low++;
      if (i == ackAt) begin
        per_ack   = 1'b1;
        per_rdata = rd;
      end
      if (intrude && i == 1) begin
        bus_valid = 1'b1;
        addr      = 16'h0005;
        r_w_n     = 1'b0;
        d_in      = 8'hFF;
      end
      @(posedge clk);
      #1;
      per_ack   = 1'b0;
      bus_valid = 1'b0;
      per_rdata = 8'($urandom);
    end
    checkOutput("per_req_drop", done, 1);
    checkOutput("rdy_low_cycles", low, timedOut ? TIMEOUT : ackAt + 1);
    checkOutput("rdy_after", {31'd0, rdy}, 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    bus_valid = 1'b0;
    addr      = 16'h0000;
    r_w_n     = 1'b1;
    d_in      = 8'h00;
    per_rdata = 8'h00;
    per_ack   = 1'b0;
    openBus   = 8'h00;
    idle(3);
    reset = 1'b0;
    idle(1);

    checkOutput("rst_d_oe", {31'd0, d_oe}, 32'd0);
    checkOutput("rst_resp", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst_rdy", {31'd0, rdy}, 32'd1);
    checkOutput("rst_per_req", {31'd0, per_req}, 32'd0);
    checkOutput("rst_per_we", {31'd0, per_we}, 32'd0);
    checkOutput("rst_per_addr", {29'd0, per_addr}, 32'd0);
    checkOutput("rst_per_wdata", {24'd0, per_wdata}, 32'd0);
    checkOutput("rst_d_out", {24'd0, d_out}, 32'd0);

    // Open bus starts at zero
    applyStimulus(16'h9000, 1'b1, 8'h00);

    // RAM write and mirrored reads
    applyStimulus(16'h0005, 1'b0, 8'hA5);
    applyStimulus(16'h0805, 1'b1, 8'h00);
    applyStimulus(16'h1805, 1'b1, 8'h00);

    perAccess(16'h2002, 1'b1, 8'h00, 3, 8'h80, 1'b0);
    perAccess(16'h3FF9, 1'b0, 8'h1E, 0, 8'h00, 1'b0);
    perAccess(16'h2007, 1'b1, 8'h00, 99, 8'h00, 1'b0);
    perAccess(16'h2004, 1'b1, 8'h00, TIMEOUT - 1, 8'h6B, 1'b0);
    perAccess(16'h2006, 1'b0, 8'h44, TIMEOUT - 1, 8'h00, 1'b0);

    // A bus cycle during PER_WAIT must not reach RAM
    perAccess(16'h2001, 1'b0, 8'h33, 5, 8'h00, 1'b1);
    applyStimulus(16'h0805, 1'b1, 8'h00);

    applyStimulus(16'h0000, 1'b0, 8'h3C);
    applyStimulus(16'h5000, 1'b1, 8'h00);

    // Stray acks while idle produce nothing
    per_ack   = 1'b1;
    per_rdata = 8'h99;
    idle(2);
    per_ack = 1'b0;
    idle(1);

    // Reset while waiting on a peripheral aborts silently
    drive(16'h2003, 1'b1, 8'h00);
    idle(3);
    reset = 1'b1;
    idle(1);
    reset   = 1'b0;
    openBus = 8'h00;
    checkOutput("rst_mid_per_req", {31'd0, per_req}, 32'd0);
    checkOutput("rst_mid_rdy", {31'd0, rdy}, 32'd1);
    idle(3);
    applyStimulus(16'hC123, 1'b1, 8'h00);

    // Prefill a small RAM region so random reads hit known data
    for (int i = 0; i < 32; i++) applyStimulus(16'(i), 1'b0, 8'($urandom));

    for (int n = 0; n < 250; n++) begin
      int          kind;
      logic [15:0] a;
      logic [1:0]  mir;
      logic [4:0]  idx;
      kind = $urandom_range(0, 5);
      mir  = 2'($urandom);
      idx  = 5'($urandom);
      case (kind)
        0:       applyStimulus({3'b000, mir, 6'd0, idx}, 1'b0, 8'($urandom));
        1:       applyStimulus({3'b000, mir, 6'd0, idx}, 1'b1, 8'h00);
        2:       applyStimulus(16'($urandom_range(16'h4000, 16'hFFFF)), 1'b0, 8'($urandom));
        3:       applyStimulus(16'($urandom_range(16'h4000, 16'hFFFF)), 1'b1, 8'h00);
        default: begin
          a = 16'h2000 | 16'($urandom_range(0, 16'h1FFF));
          perAccess(a, 1'($urandom), 8'($urandom), $urandom_range(0, TIMEOUT + 2),
                    8'($urandom), 1'b0);
        end
      endcase
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end

    for (int i = 0; i < 100 && expQ.size() != 0; i++) idle(1);
    checkOutput("queue_drained", expQ.size(), 0);
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
